mvu_rdc_scheduler: RTL and testbench



---
 rtl/mvu_pkg.sv | 33 +++
 rtl/rdc_rr_arbiter.sv | 27 ++
 rtl/mvu_rdc_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_mvu_rdc_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared types and sizing for the MVU result read-client scheduler.
// Used by mvu_rdc_scheduler and rdc_rr_arbiter.
package mvu_pkg;

    localparam int NMVU       = 8;
    localparam int BDBANKA    = 15;
    localparam int BDBANKW    = 64;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int LENW       = 8;
    localparam int MW         = $clog2(NMVU);
    localparam int FAW        = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        READ,
        DRAIN
    } rdc_state_t;

    typedef struct packed {
        logic [MW-1:0] mvu;
        logic          last;
    } rdc_tag_t;

    function automatic logic [NMVU-1:0] onehot(input logic [MW-1:0] idx);
        logic [NMVU-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rdc_rr_arbiter.sv
// Combinational round-robin pick: first pending index at or after the
// pointer, wrapping around.
module rdc_rr_arbiter
    import mvu_pkg::*;
(
    input  logic [NMVU-1:0] i_pending,
    input  logic [MW-1:0]   i_ptr,
    output logic [MW-1:0]   o_sel,
    output logic            o_any
);

    logic [MW-1:0] w_idx;

    always_comb begin
        o_sel = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NMVU; k++) begin
            w_idx = MW'((int'(i_ptr) + k) % NMVU);
            if (!o_any && i_pending[w_idx]) begin
                o_sel = w_idx;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mvu_rdc_scheduler.sv
// Reads finished MVU result blocks and merges them into one credit-limited stream.
// Optional perf counters: define BARVINN_RDC_PERF_EN.
module mvu_rdc_scheduler
    import mvu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [MW-1:0]             cfg_mvu,
    input  logic [BDBANKA-1:0]        cfg_base,
    input  logic [LENW-1:0]           cfg_len,
    input  logic [NMVU-1:0]           mvu_irq_tap,
    output logic [NMVU-1:0]           mvu_rdc_en,
    output logic [NMVU*BDBANKA-1:0]   mvu_rdc_addr,
    input  logic [NMVU-1:0]           mvu_rdc_grnt,
    input  logic [NMVU*BDBANKW-1:0]   mvu_rdc_word,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BDBANKW-1:0]        out_data,
    output logic [MW-1:0]             out_mvu,
    output logic                      out_last,
    output logic [NMVU-1:0]           pending,
    output logic                      busy
`ifdef BARVINN_RDC_PERF_EN
    ,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_jobs
`endif
);

    localparam int CW = FAW + 2;

    rdc_state_t         r_state;
    rdc_state_t         w_state_nxt;
    logic [MW-1:0]      r_ptr;
    logic [MW-1:0]      r_sel;
    logic [BDBANKA-1:0] r_addr;
    logic [LENW-1:0]    r_rem;
    logic [NMVU-1:0]    r_pending;
    logic [BDBANKA-1:0] r_base [NMVU];
    logic [LENW-1:0]    r_len  [NMVU];

    logic [RD_LAT-1:0]  r_pv;
    rdc_tag_t           r_ptag [RD_LAT];

    logic [BDBANKW-1:0] r_fdata [FIFO_DEPTH];
    rdc_tag_t           r_ftag  [FIFO_DEPTH];
    logic [FAW-1:0]     r_wp;
    logic [FAW-1:0]     r_rp;
    logic [FAW:0]       r_cnt;

    logic [MW-1:0]      w_sel;
    logic               w_any;
    logic               w_arb;
    logic [NMVU-1:0]    w_clr;
    logic [CW-1:0]      w_inflight;
    logic [CW-1:0]      w_used;
    logic               w_req;
    logic               w_acc;
    logic               w_push;
    logic               w_pop;
    logic [BDBANKW-1:0] w_word;

    rdc_rr_arbiter u_arb (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_sel     (w_sel),
        .o_any     (w_any)
    );

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            w_inflight = w_inflight + CW'(r_pv[k]);
        end
    end

    // Credits count both FIFO entries and reads still in the return pipe.
    assign w_used = CW'(r_cnt) + w_inflight;
    assign w_arb  = (r_state == ARB);
    assign w_clr  = (w_arb && w_any) ? onehot(w_sel) : '0;
    assign w_req  = (r_state == READ) && (w_used < CW'(FIFO_DEPTH));
    assign w_acc  = w_req && mvu_rdc_grnt[r_sel];
    assign w_push = r_pv[RD_LAT-1];
    assign w_pop  = out_valid && out_ready;
    assign w_word = mvu_rdc_word[int'(r_ptag[RD_LAT-1].mvu)*BDBANKW +: BDBANKW];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (|r_pending) w_state_nxt = ARB;
            end
            ARB: begin
                if (!w_any || r_len[w_sel] == '0) w_state_nxt = IDLE;
                else                              w_state_nxt = READ;
            end
            READ: begin
                if (w_acc && r_rem == LENW'(1)) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_inflight == '0) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mvu_rdc_en   = '0;
        mvu_rdc_addr = '0;
        if (w_req) begin
            mvu_rdc_en = onehot(r_sel);
            mvu_rdc_addr[int'(r_sel)*BDBANKA +: BDBANKA] = r_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_addr    <= '0;
            r_rem     <= '0;
            r_pending <= '0;
            r_pv      <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            for (int k = 0; k < NMVU; k++) begin
                r_base[k] <= '0;
                r_len[k]  <= '0;
            end
            for (int k = 0; k < RD_LAT; k++) begin
                r_ptag[k] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending & ~w_clr) | mvu_irq_tap;
            if (cfg_we) begin
                r_base[cfg_mvu] <= cfg_base;
                r_len[cfg_mvu]  <= cfg_len;
            end
            if (w_arb && w_any) begin
                r_sel  <= w_sel;
                r_ptr  <= MW'((int'(w_sel) + 1) % NMVU);
                r_addr <= r_base[w_sel];
                r_rem  <= r_len[w_sel];
            end
            if (w_acc) begin
                r_addr <= r_addr + BDBANKA'(1);
                r_rem  <= r_rem - LENW'(1);
            end
            r_pv[0]   <= w_acc;
            r_ptag[0] <= '{mvu: r_sel, last: (r_rem == LENW'(1))};
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k]   <= r_pv[k-1];
                r_ptag[k] <= r_ptag[k-1];
            end
            if (w_push) r_wp <= r_wp + FAW'(1);
            if (w_pop)  r_rp <= r_rp + FAW'(1);
            r_cnt <= r_cnt + (FAW+1)'(w_push) - (FAW+1)'(w_pop);
        end
    end

    // Storage only; validity is tracked by r_cnt, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fdata[r_wp] <= w_word;
            r_ftag[r_wp]  <= r_ptag[RD_LAT-1];
        end
    end

    assign out_valid = (r_cnt != '0);
    assign out_data  = out_valid ? r_fdata[r_rp]     : '0;
    assign out_mvu   = out_valid ? r_ftag[r_rp].mvu  : '0;
    assign out_last  = out_valid ? r_ftag[r_rp].last : 1'b0;
    assign pending   = r_pending;
    assign busy      = (r_state != IDLE) || out_valid;

`ifdef BARVINN_RDC_PERF_EN
    logic [31:0] r_stall;
    logic [31:0] r_jobs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
            r_jobs  <= '0;
        end else begin
            if ((|mvu_rdc_en) && !w_acc && r_stall != '1) begin
                r_stall <= r_stall + 32'd1;
            end
            if (w_arb && w_any && r_len[w_sel] != '0 && r_jobs != '1) begin
                r_jobs <= r_jobs + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_stall;
    assign perf_jobs      = r_jobs;
`endif

endmodule

// File: tb/tb_mvu_rdc_scheduler.sv
// Scoreboard bench for mvu_rdc_scheduler: random bank grants, sink stalls
// and job batches checked against a job-level round-robin model.
module tb_mvu_rdc_scheduler;
    import mvu_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cfg_we;
    logic [MW-1:0]           cfg_mvu;
    logic [BDBANKA-1:0]      cfg_base;
    logic [LENW-1:0]         cfg_len;
    logic [NMVU-1:0]         mvu_irq_tap;
    logic [NMVU-1:0]         mvu_rdc_en;
    logic [NMVU*BDBANKA-1:0] mvu_rdc_addr;
    logic [NMVU-1:0]         mvu_rdc_grnt;
    logic [NMVU*BDBANKW-1:0] mvu_rdc_word;
    logic                    out_valid;
    logic                    out_ready;
    logic [BDBANKW-1:0]      out_data;
    logic [MW-1:0]           out_mvu;
    logic                    out_last;
    logic [NMVU-1:0]         pending;
    logic                    busy;
`ifdef BARVINN_RDC_PERF_EN
    logic [31:0]             perf_stall_cnt;
    logic [31:0]             perf_jobs;
`endif

    always #5 clk = ~clk;

    mvu_rdc_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_mvu      (cfg_mvu),
        .cfg_base     (cfg_base),
        .cfg_len      (cfg_len),
        .mvu_irq_tap  (mvu_irq_tap),
        .mvu_rdc_en   (mvu_rdc_en),
        .mvu_rdc_addr (mvu_rdc_addr),
        .mvu_rdc_grnt (mvu_rdc_grnt),
        .mvu_rdc_word (mvu_rdc_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_mvu      (out_mvu),
        .out_last     (out_last),
        .pending      (pending),
        .busy         (busy)
`ifdef BARVINN_RDC_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_jobs      (perf_jobs)
`endif
    );

    typedef struct {
        logic [63:0] d;
        int          m;
        bit          last;
    } exp_t;

    typedef struct {
        int          due;
        int          m;
        logic [14:0] a;
    } rd_t;

    exp_t        sbq[$];
    rd_t         bq[$];
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          gnt_pct = 70;
    int          rdy_pct = 80;
    int          grants  = 0;
    bit          en_seen = 1'b0;
    logic [14:0] m_base[NMVU];
    int          m_len[NMVU];
    int          m_ptr   = 0;

    function automatic logic [63:0] bank(input int m, input logic [14:0] a);
        logic [31:0] h;
        h = (32'(a) * 32'h9E3779B1) ^ 32'(m);
        return {4'(m), 12'hA5C, 1'b0, a, h};
    endfunction

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Data bank + sink + output monitor, all driven away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        mvu_rdc_grnt = '0;
        for (int i = 0; i < NMVU; i++) begin
            mvu_rdc_word[i*BDBANKW +: BDBANKW] = {$urandom, $urandom};
        end
        if (bq.size() > 0 && bq[0].due == cyc) begin
            mvu_rdc_word[bq[0].m*BDBANKW +: BDBANKW] = bank(bq[0].m, bq[0].a);
            void'(bq.pop_front());
        end
        if (mvu_rdc_en != '0) begin
            en_seen = 1'b1;
            chk("en_onehot", 64'($countones(mvu_rdc_en)), 64'd1);
            for (int i = 0; i < NMVU; i++) begin
                if (mvu_rdc_en[i] && $urandom_range(99) < gnt_pct) begin
                    mvu_rdc_grnt[i] = 1'b1;
                    bq.push_back('{cyc + RD_LAT, i,
                                   mvu_rdc_addr[i*BDBANKA +: BDBANKA]});
                    grants++;
                end
            end
        end
        out_ready = ($urandom_range(99) < rdy_pct);
        #1;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h from mvu %0d expected none",
                         out_data, out_mvu);
            end else begin
                e = sbq.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_mvu", 64'(out_mvu), 64'(e.m));
                chk("out_last", 64'(out_last), 64'(e.last));
            end
        end
    end

    task automatic cfg(input int m, input logic [14:0] b, input int l);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_mvu  = MW'(m);
        cfg_base = b;
        cfg_len  = LENW'(l);
        @(negedge clk);
        cfg_we   = 1'b0;
        m_base[m] = b;
        m_len[m]  = l;
    endtask

    // Round-robin job order from the model pointer; one stream per job.
    task automatic model_jobs(input logic [NMVU-1:0] set);
        int start;
        int idx;
        start = m_ptr;
        for (int k = 0; k < NMVU; k++) begin
            idx = (start + k) % NMVU;
            if (set[idx]) begin
                for (int j = 0; j < m_len[idx]; j++) begin
                    sbq.push_back('{bank(idx, m_base[idx] + 15'(j)), idx,
                                    (j == m_len[idx] - 1)});
                end
                m_ptr = (idx + 1) % NMVU;
            end
        end
    endtask

    task automatic pulse(input logic [NMVU-1:0] set);
        @(negedge clk);
        mvu_irq_tap = set;
        @(negedge clk);
        mvu_irq_tap = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || pending != '0 || sbq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL timeout_%s: busy=%0b left=%0d expected idle", tag,
                     busy, sbq.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [NMVU-1:0] set;
        rst         = 1'b1;
        cfg_we      = 1'b0;
        cfg_mvu     = '0;
        cfg_base    = '0;
        cfg_len     = '0;
        mvu_irq_tap = '0;
        mvu_rdc_grnt = '0;
        mvu_rdc_word = '0;
        out_ready   = 1'b0;
        for (int i = 0; i < NMVU; i++) begin
            m_base[i] = '0;
            m_len[i]  = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_en", 64'(mvu_rdc_en), 64'd0);

        // Two simultaneous jobs from pointer 0: MVU0 then MVU5.
        cfg(0, 15'h0100, 2);
        cfg(5, 15'h0200, 2);
        model_jobs(8'h21);
        @(negedge clk);
        mvu_irq_tap = 8'h21;
        @(negedge clk);
        mvu_irq_tap = '0;
        chk("pend_set", 64'(pending), 64'h21);
        @(negedge clk);
        @(negedge clk);
        chk("pend_after_arb", 64'(pending), 64'h20);
        chk("first_en", 64'(mvu_rdc_en), 64'h01);
        chk("first_addr", 64'(mvu_rdc_addr[0 +: BDBANKA]), 64'h100);
        wait_idle("two_jobs");
        chk("pend_clear", 64'(pending), 64'h00);

        // Basic job on MVU2.
        cfg(2, 15'h0010, 3);
        model_jobs(8'h04);
        pulse(8'h04);
        wait_idle("mvu2");

        // Sink stalled: credits cap outstanding reads at FIFO_DEPTH.
        rdy_pct = 0;
        gnt_pct = 100;
        cfg(3, 15'h0040, 10);
        model_jobs(8'h08);
        grants = 0;
        pulse(8'h08);
        repeat (30) @(negedge clk);
        chk("credit_cap", 64'(grants), 64'(FIFO_DEPTH));
        chk("stall_valid", 64'(out_valid), 64'd1);
        rdy_pct = 80;
        gnt_pct = 70;
        wait_idle("backpressure");

        // Address wrap.
        cfg(4, 15'h7FFF, 2);
        model_jobs(8'h10);
        pulse(8'h10);
        wait_idle("wrap");

        // Zero-length job.
        cfg(6, 15'h0123, 0);
        model_jobs(8'h40);
        en_seen = 1'b0;
        pulse(8'h40);
        wait_idle("len0");
        chk("len0_no_en", 64'(en_seen), 64'd0);
        chk("len0_pend", 64'(pending), 64'd0);

        // Re-trigger during READ re-runs the job.
        cfg(1, 15'h0500, 8);
        model_jobs(8'h02);
        model_jobs(8'h02);
        pulse(8'h02);
        repeat (3) @(negedge clk);
        pulse(8'h02);
        wait_idle("rerun");

        // Reset while reads are in flight.
        gnt_pct = 100;
        rdy_pct = 0;
        cfg(7, 15'h0300, 10);
        model_jobs(8'h80);
        grants = 0;
        pulse(8'h80);
        n = 0;
        while (grants < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_grants", 64'(grants >= 2), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_data", out_data, 64'd0);
        chk("midrst_en", 64'(mvu_rdc_en), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_pend", 64'(pending), 64'd0);
        sbq.delete();
        bq.delete();
        m_ptr = 0;
        for (int i = 0; i < NMVU; i++) begin
            m_base[i] = '0;
            m_len[i]  = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        gnt_pct = 70;
        rdy_pct = 80;
        repeat (20) @(negedge clk);
        chk("postrst_valid", 64'(out_valid), 64'd0);
        cfg(7, 15'h0300, 3);
        model_jobs(8'h80);
        pulse(8'h80);
        wait_idle("postrst");

        // Random batches.
        for (int b = 0; b < 25; b++) begin
            for (int m = 0; m < NMVU; m++) begin
                if ($urandom_range(1) == 1) begin
                    if ($urandom_range(3) == 0) begin
                        cfg(m, 15'h7FF8 + 15'($urandom_range(7)),
                            $urandom_range(9));
                    end else begin
                        cfg(m, 15'($urandom), $urandom_range(9));
                    end
                end
            end
            set = NMVU'($urandom_range(255, 1));
            gnt_pct = $urandom_range(100, 30);
            rdy_pct = $urandom_range(100, 20);
            model_jobs(set);
            pulse(set);
            wait_idle("batch");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
